// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared widths and FSM encoding for the shared BCD conversion engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int NREQ_DEF = 4;
    localparam int BIN_W    = 8;
    localparam int BCD_W    = 10;
    localparam int SH_W     = BIN_W + BCD_W;
    localparam int ITER_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_dd_step.sv
// ============================================================================
// Module  : bcd_dd_step
// Brief   : One double-dabble iteration: add-3 on ones/tens digits, then shift left.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_dd_step
    import bcd_pkg::*;
(
    input  logic [SH_W-1:0] sh_i,
    output logic [SH_W-1:0] sh_o
);

    logic [SH_W-1:0] adj;

    // Hundreds never exceeds 2 for an 8-bit operand, so it needs no correction.
    always_comb begin
        adj = sh_i;
        if (sh_i[11:8] >= 4'd5) begin
            adj[11:8] = sh_i[11:8] + 4'd3;
        end
        if (sh_i[15:12] >= 4'd5) begin
            adj[15:12] = sh_i[15:12] + 4'd3;
        end
        sh_o = {adj[SH_W-2:0], 1'b0};
    end

endmodule

`default_nettype wire

// File: rtl/bcd_conv_sched.sv
// ============================================================================
// Module  : bcd_conv_sched
// Brief   : Round-robin scheduler sharing one 8-bit BCD engine among NREQ requesters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    freeze,
    input  logic [NREQ-1:0]         req_i,
    input  logic [BIN_W*NREQ-1:0]   bin_i,
    output logic [NREQ-1:0]         ack_o,
    output logic [BCD_W*NREQ-1:0]   bcd_o,
    output logic                    busy_o
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t                         state_q, state_d;
    logic [SH_W-1:0]                shift_q, shift_d;
    logic [ITER_W-1:0]              iter_q,  iter_d;
    logic [PTR_W-1:0]               win_q,   win_d;
    logic [PTR_W-1:0]               rr_q,    rr_d;
    logic [NREQ-1:0][BCD_W-1:0]     bcd_q,   bcd_d;
    logic [NREQ-1:0]                ack_q,   ack_d;
    logic                           busy_q,  busy_d;

    logic [NREQ-1:0][BIN_W-1:0]     bin_v;
    logic [SH_W-1:0]                step_out;
    logic [PTR_W-1:0]               grant;
    logic                           found;

    assign bin_v  = bin_i;
    assign ack_o  = ack_q;
    assign bcd_o  = bcd_q;
    assign busy_o = busy_q;

    bcd_dd_step u_step (
        .sh_i (shift_q),
        .sh_o (step_out)
    );

    // Scan starts one past the last winner so every held request is served in turn.
    always_comb begin
        logic [PTR_W-1:0] cand;
        found = 1'b0;
        grant = rr_q;
        cand  = rr_q;
        for (int i = 0; i < NREQ; i++) begin
            cand = (cand == PTR_W'(NREQ - 1)) ? '0 : cand + PTR_W'(1);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        win_d   = win_q;
        rr_d    = rr_q;
        bcd_d   = bcd_q;
        ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (found && !freeze) begin
                    shift_d = {{(SH_W - BIN_W){1'b0}}, bin_v[grant]};
                    win_d   = grant;
                    iter_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = step_out;
                iter_d  = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(7)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d[win_q] = shift_q[SH_W-1:BIN_W];
                ack_d[win_q] = 1'b1;
                rr_d         = win_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            iter_q  <= '0;
            win_q   <= '0;
            rr_q    <= PTR_W'(NREQ - 1);
            bcd_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            iter_q  <= iter_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
            bcd_q   <= bcd_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_sched.sv
// ============================================================================
// Module  : tb_bcd_conv_sched
// Brief   : Directed self-checking bench for the shared BCD conversion scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_conv_sched;
    import bcd_pkg::*;

    localparam int N = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       freeze;
    logic [N-1:0]               req_i;
    logic [N*BIN_W-1:0]         bin_i;
    logic [N-1:0]               ack_o;
    logic [N*BCD_W-1:0]         bcd_o;
    logic                       busy_o;

    logic [N-1:0][BIN_W-1:0]    bin_v;
    logic [N-1:0][BCD_W-1:0]    exp_bank;
    logic [BCD_W-1:0]           rr_exp [N];

    int total = 0;
    int bad   = 0;

    assign bin_i = bin_v;

    always #5 clk = ~clk;

    bcd_conv_sched #(.NREQ(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .freeze (freeze),
        .req_i  (req_i),
        .bin_i  (bin_i),
        .ack_o  (ack_o),
        .bcd_o  (bcd_o),
        .busy_o (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drops req right after grant and scrambles the operand to prove it was latched.
    task automatic convert(input int slot, input logic [BIN_W-1:0] bin, input logic [BCD_W-1:0] exp);
        logic [N-1:0] oh;
        oh       = '0;
        oh[slot] = 1'b1;
        bin_v[slot] = bin;
        req_i       = oh;
        tick();
        check("grant_busy", 64'(busy_o), 64'd1);
        req_i       = '0;
        bin_v[slot] = ~bin;
        repeat (8) tick();
        check("no_early_ack", 64'(ack_o), 64'd0);
        tick();
        exp_bank[slot] = exp;
        check("ack_t9", 64'(ack_o), 64'(oh));
        check("bcd_bank", 64'(bcd_o), 64'(exp_bank));
        check("busy_after", 64'(busy_o), 64'd0);
        tick();
        check("ack_pulse", 64'(ack_o), 64'd0);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ack_o == '0 && n < 30);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [N-1:0] oh;
        rst_n    = 1'b0;
        freeze   = 1'b0;
        req_i    = '0;
        bin_v    = '0;
        exp_bank = '0;
        rr_exp[0] = 10'h012;
        rr_exp[1] = 10'h034;
        rr_exp[2] = 10'h056;
        rr_exp[3] = 10'h078;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 64'(ack_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_bcd", 64'(bcd_o), 64'd0);
        rst_n = 1'b1;
        tick();

        convert(0, 8'd255, 10'h255);
        convert(1, 8'd0,   10'h000);
        convert(2, 8'd99,  10'h099);
        convert(3, 8'd100, 10'h100);
        convert(0, 8'd59,  10'h059);

        // Reset while the engine is mid-way through iterations.
        bin_v[2] = 8'd200;
        req_i    = 4'b0100;
        tick();
        req_i = '0;
        repeat (4) tick();
        check("mid_busy", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", 64'(ack_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_bcd", 64'(bcd_o), 64'd0);
        exp_bank = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        bin_v[0] = 8'd12;
        bin_v[1] = 8'd34;
        bin_v[2] = 8'd56;
        bin_v[3] = 8'd78;
        req_i    = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(n);
            if (i == 4) req_i = '0;
            oh         = '0;
            oh[i % N]  = 1'b1;
            exp_bank[i % N] = rr_exp[i % N];
            check("rr_gap", 64'(n), 64'd10);
            check("rr_ack", 64'(ack_o), 64'(oh));
            check("rr_bcd", 64'(bcd_o), 64'(exp_bank));
        end
        tick();
        check("drop_no_grant", 64'(busy_o), 64'd0);

        // Freeze raised mid-conversion of slot 1 with slots 1 and 2 both requesting.
        bin_v[1] = 8'd200;
        bin_v[2] = 8'd150;
        req_i    = 4'b0110;
        tick();
        check("frz_grant", 64'(busy_o), 64'd1);
        bin_v[1] = 8'd7;
        repeat (3) tick();
        freeze = 1'b1;
        repeat (6) tick();
        exp_bank[1] = 10'h200;
        check("frz_ack", 64'(ack_o), 64'b0010);
        check("frz_bcd", 64'(bcd_o), 64'(exp_bank));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("frz_idle_busy", 64'(busy_o), 64'd0);
            check("frz_idle_ack", 64'(ack_o), 64'd0);
        end
        check("frz_bcd_hold", 64'(bcd_o), 64'(exp_bank));
        freeze = 1'b0;
        tick();
        check("unfrz_grant", 64'(busy_o), 64'd1);
        req_i = '0;
        repeat (8) tick();
        check("unfrz_no_early", 64'(ack_o), 64'd0);
        tick();
        exp_bank[2] = 10'h150;
        check("unfrz_ack", 64'(ack_o), 64'b0100);
        check("unfrz_bcd", 64'(bcd_o), 64'(exp_bank));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
